// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: DEPTH-stage valid/ready pipeline register with bubble collapse, flush and zeroed ctrl on empty stages
module pipe_stage_elastic #(
  parameter int CTRL_W = 2,
  parameter int DATA_W = 69,
  parameter int DEPTH = 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  occupancy
);
  logic [DEPTH-1:0] v_q, v_d, rdy, sv;
  logic [CTRL_W-1:0] c_q [DEPTH];
  logic [CTRL_W-1:0] c_d [DEPTH];
  logic [CTRL_W-1:0] sc [DEPTH];
  logic [DATA_W-1:0] d_q [DEPTH];
  logic [DATA_W-1:0] d_d [DEPTH];
  logic [DATA_W-1:0] sd [DEPTH];
  logic [CNT_W-1:0] occ_q, occ_d;
  logic r;
  always_comb begin
    r = out_ready;
    rdy = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      r = r | ~v_q[i];
      rdy[i] = r;
    end
  end
  always_comb begin
    sv[0] = in_valid;
    sc[0] = in_ctrl;
    sd[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      sv[i] = v_q[i-1];
      sc[i] = c_q[i-1];
      sd[i] = d_q[i-1];
    end
  end
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      v_d[i] = flush ? 1'b0 : rdy[i] ? sv[i] : v_q[i];
      c_d[i] = flush ? '0 : rdy[i] ? (sv[i] ? sc[i] : '0) : c_q[i];
      d_d[i] = (rdy[i] && sv[i] && !flush) ? sd[i] : d_q[i];
    end
    occ_d = CNT_W'($countones(v_d));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q <= '0;
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        c_q[i] <= '0;
        d_q[i] <= '0;
      end
    end else begin
      v_q <= v_d;
      c_q <= c_d;
      d_q <= d_d;
      occ_q <= occ_d;
    end
  end
  assign in_ready = rdy[0] & ~flush;
  assign out_valid = v_q[DEPTH-1] & ~flush;
  assign out_ctrl = out_valid ? c_q[DEPTH-1] : '0;
  assign out_data = d_q[DEPTH-1];
  assign occupancy = occ_q;
endmodule
